fpq_op_sched: RTL and testbench

- Shares one pipelined Q4.4 fixed-point ALU (add/sub/mul) between NUM_REQ activation-filter lanes.
- Each lane issues operand pairs over valid/ready.
- The block arbitrates round-robin, runs the op through a 2-stage pipeline, and returns a tagged Q8.8 result on a single response channel with backpressure.
- It sits between the per-lane activation sequencers and the shared arithmetic resource.

---
 rtl/fpq_pkg.sv | 38 +++
 rtl/fpq_rr_arbiter.sv | 55 +++++
 rtl/fpq_op_sched.sv | 141 ++++++++++++++
 tb/tb_fpq_op_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fpq_pkg.sv
// fpq_pkg: shared types and constants for the Q4.4 -> Q8.8 operator scheduler.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package fpq_pkg;

    localparam int Q44_W    = 8;
    localparam int Q88_W    = 16;
    localparam int Q44_FRAC = 4;
    localparam int Q88_FRAC = 8;

    // Clamp window: the Q8.8 values a Q4.4 number can represent.
    localparam logic [Q88_W-1:0] FPQ_SAT_MAX = 16'h07F0;
    localparam logic [Q88_W-1:0] FPQ_SAT_MIN = 16'hF800;

    typedef enum logic [1:0] {
        FPQ_ADD  = 2'd0,
        FPQ_SUB  = 2'd1,
        FPQ_MUL  = 2'd2,
        FPQ_PASS = 2'd3
    } fpq_op_e;

    // Sign-extend a Q4.4 value into Q8.8 (integer bits widen, fraction shifts up).
    function automatic logic [Q88_W-1:0] q44_to_q88(input logic [Q44_W-1:0] x);
        return {{(Q88_W - Q44_W - (Q88_FRAC - Q44_FRAC)){x[Q44_W-1]}},
                x, {(Q88_FRAC - Q44_FRAC){1'b0}}};
    endfunction

    // Clamp a Q8.8 value into the Q4.4-representable range.
    function automatic logic [Q88_W-1:0] q88_sat(input logic [Q88_W-1:0] x);
        if ($signed(x) > $signed(FPQ_SAT_MAX)) begin
            return FPQ_SAT_MAX;
        end else if ($signed(x) < $signed(FPQ_SAT_MIN)) begin
            return FPQ_SAT_MIN;
        end
        return x;
    endfunction

endpackage

// File: rtl/fpq_rr_arbiter.sv
// fpq_rr_arbiter: round-robin one-hot arbiter with an internal rotating pointer.
// Latency: grant is combinational from req_i/en_i; pointer updates on the clock edge.
// Backpressure: en_i low blocks every grant and freezes the pointer.
//
// Ports: clk, rst_n (sync, active-low); req_i request vector; en_i grant enable;
//        gnt_o one-hot grant (zero when disabled or idle); idx_o index of the
//        winning requester (valid whenever any req_i bit is set).
module fpq_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             hit;

    // Search from the pointer upward, wrapping; first requester found wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!hit && req_i[(int'(ptr_q) + off) % N]) begin
                hit   = 1'b1;
                idx_o = IDX_W'((int'(ptr_q) + off) % N);
            end
        end
        if (hit && en_i) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    // Winner becomes lowest priority next time; pointer holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (hit && en_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpq_op_sched.sv
// fpq_op_sched: round-robin scheduler sharing one Q4.4 add/sub/mul/pass ALU across lanes.
// Latency: 2 clock edges from request handshake to rsp_valid; 1 op/cycle throughput.
// Backpressure: rsp_ready low freezes S2 and rsp_*; once S1 is also full every req_ready drops.
//
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready per lane; req_op
//        (2b/lane), req_a/req_b (Q4.4, 8b/lane); rsp_valid/rsp_ready, rsp_id
//        (lane tag), rsp_res (Q8.8); busy (either stage occupied).
// Build option: define FPQ_SCHED_SAT_EN to clamp rsp_res to [0xF800, 0x07F0].
module fpq_op_sched
    import fpq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [Q88_W-1:0]       rsp_res,
    output logic                   busy
);

    logic               s1_valid_q, s1_valid_d;
    fpq_op_e            s1_op_q, s1_op_d;
    logic [Q44_W-1:0]   s1_a_q, s1_a_d;
    logic [Q44_W-1:0]   s1_b_q, s1_b_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    logic [Q88_W-1:0]   s2_res_q, s2_res_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;

    logic               s1_adv, s2_adv, arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [Q88_W-1:0]   alu_res, res_fmt;
    logic [Q88_W-1:0]   a_x, b_x;
    logic [Q88_W-1:0]   a_s, b_s;

    assign s2_adv = !s2_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    // Reset gates the arbiter so no lane sees ready while rst_n is low.
    assign arb_en = s1_adv && rst_n;

    fpq_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_valid),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign req_ready = gnt;

    // S2 compute: all ops produce exact Q8.8 results in 16 bits.
    always_comb begin
        a_x     = q44_to_q88(s1_a_q);
        b_x     = q44_to_q88(s1_b_q);
        a_s     = {{(Q88_W-Q44_W){s1_a_q[Q44_W-1]}}, s1_a_q};
        b_s     = {{(Q88_W-Q44_W){s1_b_q[Q44_W-1]}}, s1_b_q};
        alu_res = '0;
        case (s1_op_q)
            FPQ_ADD:  alu_res = a_x + b_x;
            FPQ_SUB:  alu_res = a_x - b_x;
            // Q4.4 * Q4.4 is natively Q8.8; low 16 bits of the sign-extended product are exact.
            FPQ_MUL:  alu_res = a_s * b_s;
            FPQ_PASS: alu_res = a_x;
            default:  alu_res = '0;
        endcase
`ifdef FPQ_SCHED_SAT_EN
        res_fmt = q88_sat(alu_res);
`else
        res_fmt = alu_res;
`endif
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_id_d    = s2_id_q;
        if (s1_adv) begin
            s1_valid_d = |gnt;
            if (|gnt) begin
                s1_op_d = fpq_op_e'(req_op[2*int'(gnt_idx) +: 2]);
                s1_a_d  = req_a[8*int'(gnt_idx) +: 8];
                s1_b_d  = req_b[8*int'(gnt_idx) +: 8];
                s1_id_d = gnt_idx;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            // Data only moves with a real op so rsp_* stay put after the last response drains.
            if (s1_valid_q) begin
                s2_res_d = res_fmt;
                s2_id_d  = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= FPQ_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_res   = s2_res_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fpq_op_sched.sv
// tb_fpq_op_sched: directed self-checking bench for fpq_op_sched (NUM_REQ=4).
// Latency: inputs are driven and outputs sampled on the falling edge.
// Backpressure: rsp_ready is scripted per cycle in the stall and reset scenarios.
module tb_fpq_op_sched;
    import fpq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_res;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef FPQ_SCHED_SAT_EN
    localparam logic [15:0] EXP_SUB3   = 16'hF800;
    localparam logic [15:0] EXP_MULBIG = 16'h07F0;
`else
    localparam logic [15:0] EXP_SUB3   = 16'hF700;
    localparam logic [15:0] EXP_MULBIG = 16'h3F01;
`endif

    // Round-robin order expected with all four lanes requesting from pointer 0.
    int rr_ord [6] = '{0, 1, 2, 3, 0, 1};

    // Stall scenario, one entry per falling edge (lane0 ADD 0x0200, lane1 MUL 0x0600).
    logic [0:7]  bp_rdy     = 8'b1000_1111;
    logic [3:0]  bp_vld [8] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0};
    logic [3:0]  bp_erdy[8] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [0:7]  bp_erv     = 8'b0011_1110;
    logic [0:7]  bp_ebusy   = 8'b0111_1110;
    logic [1:0]  bp_eid [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [15:0] bp_eres[8] = '{16'h0, 16'h0, 16'h0200, 16'h0200, 16'h0200,
                                16'h0600, 16'h0200, 16'h0};

    fpq_op_sched #(
        .NUM_REQ (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b);
        req_op[2*l +: 2] = op;
        req_a[8*l +: 8]  = a;
        req_b[8*l +: 8]  = b;
    endtask

    // Single op on one lane: ready at once, response after the second rising edge.
    task automatic run_one(input string tag, input int l, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [3:0] oh;
        oh    = '0;
        oh[l] = 1'b1;
        @(negedge clk);
        set_lane(l, op, a, b);
        req_valid = oh;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = '0;
        chk({tag, ".lat1"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"}, 32'(rsp_id), 32'(l));
        chk({tag, ".res"}, 32'(rsp_res), 32'(exp));
        @(negedge clk);
        chk({tag, ".drain"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_id", 32'(rsp_id), 32'd0);
        chk("rst.rsp_res", 32'(rsp_res), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        // Single-lane ops; the pointer ends at 0 after lane 3.
        run_one("add0",   0, FPQ_ADD,  8'h4C, 8'hF0, 16'h03C0);
        run_one("mulbig", 0, FPQ_MUL,  8'h7F, 8'h7F, EXP_MULBIG);
        run_one("mulfr",  0, FPQ_MUL,  8'h18, 8'h28, 16'h03C0);
        run_one("mul2",   2, FPQ_MUL,  8'h4C, 8'hF0, 16'hFB40);
        run_one("pass1",  1, FPQ_PASS, 8'h81, 8'h00, 16'hF810);
        run_one("sub3",   3, FPQ_SUB,  8'h80, 8'h10, EXP_SUB3);

        // All lanes streaming: one grant per cycle, responses back-to-back.
        for (int i = 0; i < 4; i++) begin
            set_lane(i, FPQ_PASS, 8'(16 * (i + 1)), 8'h00);
        end
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n == 0) req_valid = 4'hF;
            if (n == 6) req_valid = 4'h0;
            #1;
            if (n < 6) chk("rr.rdy", 32'(req_ready), 32'(1 << rr_ord[n]));
            if (n >= 2 && n < 8) begin
                chk("rr.vld", 32'(rsp_valid), 32'd1);
                chk("rr.id", 32'(rsp_id), 32'(rr_ord[n-2]));
                chk("rr.res", 32'(rsp_res), 32'(16'h0100 * (rr_ord[n-2] + 1)));
            end
            if (n == 8) chk("rr.end", 32'(rsp_valid), 32'd0);
        end

        // Lanes 0/1 under a three-cycle response stall; pointer starts at 2.
        set_lane(0, FPQ_ADD, 8'h10, 8'h10);
        set_lane(1, FPQ_MUL, 8'h20, 8'h30);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            rsp_ready = bp_rdy[n];
            req_valid = bp_vld[n];
            #1;
            chk("bp.rdy", 32'(req_ready), 32'(bp_erdy[n]));
            chk("bp.busy", 32'(busy), 32'(bp_ebusy[n]));
            chk("bp.vld", 32'(rsp_valid), 32'(bp_erv[n]));
            if (bp_erv[n]) begin
                chk("bp.id", 32'(rsp_id), 32'(bp_eid[n]));
                chk("bp.res", 32'(rsp_res), 32'(bp_eres[n]));
            end
        end

        // Fill both stages (pointer at 1), then a one-cycle reset.
        set_lane(0, FPQ_PASS, 8'h10, 8'h00);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("rs.fill1", 32'(req_ready), 32'h2);
        @(negedge clk);
        #1;
        chk("rs.fill2", 32'(req_ready), 32'h4);
        @(negedge clk);
        chk("rs.full.vld", 32'(rsp_valid), 32'd1);
        chk("rs.full.id", 32'(rsp_id), 32'd1);
        chk("rs.full.res", 32'(rsp_res), 32'h0600);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("rs.rdy_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        chk("rs.vld", 32'(rsp_valid), 32'd0);
        chk("rs.busy", 32'(busy), 32'd0);
        chk("rs.id", 32'(rsp_id), 32'd0);
        chk("rs.res", 32'(rsp_res), 32'd0);
        #1;
        chk("rs.ptr", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        chk("rs.lat1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rs.new.vld", 32'(rsp_valid), 32'd1);
        chk("rs.new.id", 32'(rsp_id), 32'd0);
        chk("rs.new.res", 32'(rsp_res), 32'h0100);
        @(negedge clk);
        chk("rs.nostale", 32'(rsp_valid), 32'd0);
        chk("rs.idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
